div_seq: RTL and testbench

- Iterative multi-cycle divider sequencer serving the EX stage's DIV/DIVU path.
- Accepts operands plus a start request from EX and runs a radix-2 restoring division, one quotient bit per cycle.
- Returns {remainder, quotient} with a ready flag. EX holds its stall request until ready.
- Sits beside EX. Driven by EX's div_opdata1/2, div_start and signed_div outputs; drives EX's div_result and div_ready inputs.

---
 rtl/div_seq_if.sv | 23 ++
 rtl/div_seq.sv | 146 ++++++++++++++
 tb/tb_div_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Operand/result bundle between the EX stage and the iterative divider.
// Handshake: EX raises start_i with stable operands and holds it until it sees ready_o; the divider holds ready_o/result_o until start_i drops.
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, returns {remainder, quotient}.
// Operates on magnitudes and applies the sign fixup when the result is loaded.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        Rst_n,
    div_seq_if.slave    bus,
    output logic [1:0]  state_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W:0]     work_q, work_d;
    logic [DATA_W-1:0]     dvsr_q, dvsr_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic [DATA_W-1:0]     mag_a, mag_b;
    logic [DATA_W:0]       rem_shift;
    logic [DATA_W+1:0]     diff;
    logic [DATA_W-1:0]     quot_fix, rem_fix;
    logic                  unused_msb;

    assign mag_a = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign mag_b = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
    assign rem_shift = work_q[2*DATA_W-1:DATA_W-1];
    assign diff      = {1'b0, rem_shift} - {2'b00, dvsr_q};

    // The partial remainder never exceeds the divisor, so the top work bit stays zero.
    assign unused_msb = work_q[2*DATA_W];

    assign quot_fix = neg_quot_q ? -work_q[DATA_W-1:0]        : work_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q  ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q    <= S_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            dvsr_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            dvsr_q     <= dvsr_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        dvsr_d     = dvsr_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        work_d     = {{(DATA_W+1){1'b0}}, mag_a};
                        dvsr_d     = mag_b;
                        neg_quot_d = bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                        neg_rem_d  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                    end
                end
            end
            S_BYZERO: begin
                work_d     = '0;
                neg_quot_d = 1'b0;
                neg_rem_d  = 1'b0;
                cnt_d      = '0;
                state_d    = S_END;
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    if (diff[DATA_W+1]) begin
                        work_d = {work_q[2*DATA_W-1:0], 1'b0};
                    end else begin
                        work_d = {diff[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                // First END cycle loads the result even if start_i already dropped.
                if (bus.annul_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (!ready_q) begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end else if (!bus.start_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d = S_FREE;
            end
        endcase
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide-by-zero, overflow, annul, reset and hold behaviour.
module tb_div_seq;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       Rst_n;
    logic [1:0] state_o;

    div_seq_if #(.DATA_W(W)) dif ();

    div_seq #(.DATA_W(W)) dut (
        .clk     (clk),
        .Rst_n   (Rst_n),
        .bus     (dif.slave),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
    endtask

    // Returns just after the start edge E0.
    task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!dif.ready_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [2*W-1:0] exp_res);
        int n;
        exp_q.push_back(exp_res);
        launch(sgn, a, b);
        wait_ready(n);
        check_val({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check_val({tag, "_res"}, dif.result_o, exp_q.pop_front());
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_drop_rdy"}, 64'(dif.ready_o), 64'd0);
        check_val({tag, "_drop_res"}, dif.result_o, 64'd0);
    endtask

    initial begin
        int n;
        int rises;

        drive_idle();
        Rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_state", 64'(state_o), 64'd0);
        check_val("rst_rdy", 64'(dif.ready_o), 64'd0);
        check_val("rst_res", dif.result_o, 64'd0);
        Rst_n = 1'b1;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
        do_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        do_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33, {32'h0000_000F, 32'h0FFF_FFFF});
        do_div("div_by0", 1'b1, 32'd1234, 32'd0, 2, 64'd0);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});

        // Annul at cycle 10 of an ON run.
        launch(1'b0, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check_val("annul_state", 64'(state_o), 64'd0);
        check_val("annul_rdy", 64'(dif.ready_o), 64'd0);
        dif.annul_i = 1'b0;
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (dif.ready_o) rises++;
        end
        check_val("annul_never_rdy", 64'(rises), 64'd0);
        do_div("after_annul", 1'b0, 32'hFFFF_FFFF, 32'd3, 33, {32'd0, 32'h5555_5555});

        // Start and annul together in FREE: annul wins.
        @(negedge clk);
        dif.opdata1_i = 32'd10;
        dif.opdata2_i = 32'd2;
        dif.start_i   = 1'b1;
        dif.annul_i   = 1'b1;
        @(posedge clk);
        #1;
        check_val("start_annul_state", 64'(state_o), 64'd0);
        drive_idle();

        // Reset at cycle 20 of an ON run.
        launch(1'b0, 32'd1000, 32'd7);
        repeat (20) @(posedge clk);
        #1;
        Rst_n       = 1'b0;
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_state", 64'(state_o), 64'd0);
        check_val("midrst_rdy", 64'(dif.ready_o), 64'd0);
        check_val("midrst_res", dif.result_o, 64'd0);
        Rst_n = 1'b1;

        // Operands scrambled while ON; latched values must be used.
        exp_q.push_back({32'd0, 32'd100});
        launch(1'b0, 32'd1000, 32'd10);
        n = 0;
        while (!dif.ready_o && n < 60) begin
            dif.opdata1_i    = $urandom;
            dif.opdata2_i    = $urandom;
            dif.signed_div_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        check_val("toggle_lat", 64'(n), 64'd33);
        check_val("toggle_res", dif.result_o, exp_q[0]);

        // Start held through END: outputs stay put.
        repeat (5) begin
            @(posedge clk);
            #1;
            check_val("hold_rdy", 64'(dif.ready_o), 64'd1);
            check_val("hold_res", dif.result_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check_val("hold_drop_rdy", 64'(dif.ready_o), 64'd0);
        check_val("hold_drop_state", 64'(state_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
